// File: rtl/rf16x128d_queue_ctl.sv
// rf16x128d_queue_ctl: valid/ready FIFO control for a 16-entry one-hot-wordline register file with 2-entry output buffer
module rf16x128d_queue_ctl #(
    parameter int WIDTH        = 128,
    parameter int AFULL_THRESH = 12
) (
    input  logic             rclk,
    input  logic             reset_l,
    input  logic             hold,
    input  logic             enq_vld,
    input  logic [WIDTH-1:0] enq_data,
    output logic             enq_rdy,
    output logic             deq_vld,
    output logic [WIDTH-1:0] deq_data,
    input  logic             deq_rdy,
    output logic             afull,
    output logic [4:0]       occ,
    output logic [WIDTH-1:0] rf_din,
    output logic [15:0]      rf_wr_wl,
    output logic             rf_wr_en,
    output logic [15:0]      rf_rd_wl,
    output logic             rf_read_en,
    output logic             rf_sehold,
    input  logic [WIDTH-1:0] rf_dout
);
    logic [3:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [1:0]       obuf_cnt_q, obuf_cnt_d;
    logic             rd_d1_q, rd_d1_d, head_q, head_d, run_q;
    logic [WIDTH-1:0] obuf_q [2];
    logic [WIDTH-1:0] obuf_d [2];
    logic             accept, iss, pop, tail;
    logic [2:0]       obuf_nxt;

    always_comb begin
        pop        = (obuf_cnt_q != 2'd0) & deq_rdy;
        enq_rdy    = run_q & (cnt_q != 5'd16) & ~hold;
        accept     = enq_vld & enq_rdy;
        obuf_nxt   = {1'b0, obuf_cnt_q} + {2'b0, rd_d1_q} - {2'b0, pop};
        // issue only if the returning data is guaranteed a free output slot
        iss        = (cnt_q != 5'd0) & ~hold & (obuf_nxt <= 3'd1);
        cnt_d      = cnt_q + {4'b0, accept} - {4'b0, iss};
        wr_ptr_d   = wr_ptr_q + {3'b0, accept};
        rd_ptr_d   = rd_ptr_q + {3'b0, iss};
        rd_d1_d    = iss;
        obuf_cnt_d = obuf_nxt[1:0];
        head_d     = head_q ^ pop;
        tail       = head_q ^ obuf_cnt_q[0];
        obuf_d[0]  = (rd_d1_q & ~tail) ? rf_dout : obuf_q[0];
        obuf_d[1]  = (rd_d1_q & tail) ? rf_dout : obuf_q[1];
    end

    assign rf_wr_en   = accept;
    assign rf_wr_wl   = accept ? (16'd1 << wr_ptr_q) : 16'd0;
    assign rf_din     = enq_data;
    assign rf_read_en = iss;
    assign rf_rd_wl   = iss ? (16'd1 << rd_ptr_q) : 16'd0;
    assign rf_sehold  = hold;
    assign deq_vld    = obuf_cnt_q != 2'd0;
    assign deq_data   = obuf_q[head_q];
    assign afull      = cnt_q >= 5'(AFULL_THRESH);
    assign occ        = cnt_q + {4'b0, rd_d1_q} + {3'b0, obuf_cnt_q};

    always_ff @(posedge rclk or negedge reset_l) begin
        if (!reset_l) begin
            run_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_d1_q    <= 1'b0;
            obuf_cnt_q <= '0;
            head_q     <= 1'b0;
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
        end else begin
            run_q      <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_d1_q    <= rd_d1_d;
            obuf_cnt_q <= obuf_cnt_d;
            head_q     <= head_d;
            obuf_q[0]  <= obuf_d[0];
            obuf_q[1]  <= obuf_d[1];
        end
    end
endmodule
